// File: rtl/idecode_pkg.sv
// idecode_pkg: shared widths, opcodes, field positions and the decode bundle type for idecode
package idecode_pkg;
  localparam int WORD = 32;
  localparam int ADDR = 32;
  localparam int NREG = 32;
  localparam int RIDX = 5;
  localparam logic [5:0] OP_LOAD  = 6'h23;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam int OP_LSB  = 26;
  localparam int OP_W    = 6;
  localparam int RD_LSB  = 21;
  localparam int RS_LSB  = 16;
  localparam int RT_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;
  typedef struct packed {
    logic            v;
    logic [OP_W-1:0] op;
    logic [RIDX-1:0] rd;
    logic [WORD-1:0] rs_val;
    logic [WORD-1:0] rt_val;
    logic [WORD-1:0] imm;
    logic            is_load;
    logic [ADDR-1:0] pc;
  } bundle_t;
  function automatic logic [WORD-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(WORD-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction
endpackage

// File: rtl/idecode_regfile.sv
// idecode_regfile: 2-read/1-write register file, r0 hardwired to zero; IDECODE_WB_BYPASS_EN selects write-first reads
module idecode_regfile
  import idecode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RIDX-1:0] ra_i,
  input  logic [RIDX-1:0] rb_i,
  output logic [WORD-1:0] ra_o,
  output logic [WORD-1:0] rb_o,
  input  logic            we_i,
  input  logic [RIDX-1:0] wa_i,
  input  logic [WORD-1:0] wd_i
);
  logic [WORD-1:0] mem_q [NREG];
  logic [WORD-1:0] mem_d [NREG];
  logic            wr_ok;
  assign wr_ok = we_i & (wa_i != '0);
  // next contents: only the addressed non-zero entry changes, so r0 stays at its reset value of zero
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wa_i] = wd_i;
  end
  // storage, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
`ifdef IDECODE_WB_BYPASS_EN
  // write-first: a same-cycle writeback to the read index is forwarded
  always_comb begin
    ra_o = (wr_ok && wa_i == ra_i) ? wd_i : mem_q[ra_i];
    rb_o = (wr_ok && wa_i == rb_i) ? wd_i : mem_q[rb_i];
  end
`else
  // read-old: a same-cycle writeback is seen only from the next cycle on
  always_comb begin
    ra_o = mem_q[ra_i];
    rb_o = mem_q[rb_i];
  end
`endif
endmodule

// File: rtl/idecode.sv
// idecode: decode stage with register file, load-use hazard bubble, stall hold and flush (optional IDECODE_WB_BYPASS_EN)
module idecode
  import idecode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  input  logic            stall_i,
  output logic            stall_o,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [RIDX-1:0] wb_reg_i,
  input  logic [WORD-1:0] wb_data_i,
  output logic            v_o,
  output logic [OP_W-1:0] op_o,
  output logic [RIDX-1:0] rd_o,
  output logic [WORD-1:0] rs_val_o,
  output logic [WORD-1:0] rt_val_o,
  output logic [WORD-1:0] imm_o,
  output logic            is_load_o,
  output logic [ADDR-1:0] pc_o
);
  logic [OP_W-1:0] op;
  logic [RIDX-1:0] rd, rs, rt;
  logic [WORD-1:0] rs_val, rt_val;
  logic            hz;
  bundle_t         bun_q, bun_d;
  assign op = inst_i[OP_LSB +: OP_W];
  assign rd = inst_i[RD_LSB +: RIDX];
  assign rs = inst_i[RS_LSB +: RIDX];
  assign rt = inst_i[RT_LSB +: RIDX];
  idecode_regfile u_rf (
    .clk  (clk),
    .rst  (rst),
    .ra_i (rs),
    .rb_i (rt),
    .ra_o (rs_val),
    .rb_o (rt_val),
    .we_i (wb_en_i),
    .wa_i (wb_reg_i),
    .wd_i (wb_data_i)
  );
  // a load still sitting in the output register cannot feed the next instruction yet
  always_comb begin
    hz = bun_q.v & bun_q.is_load & (bun_q.rd != '0) & v_i & ((bun_q.rd == rs) | (bun_q.rd == rt));
    stall_o = v_i & (stall_i | hz) & ~flush_i & ~rst;
  end
  // next bundle: flush kills, stall holds, hazard inserts a bubble, otherwise load the decode
  always_comb begin
    bun_d = bun_q;
    if (flush_i) begin
      bun_d.v = 1'b0;
    end else if (stall_i) begin
      bun_d = bun_q;
    end else if (hz) begin
      bun_d.v = 1'b0;
    end else begin
      bun_d.v       = v_i;
      bun_d.op      = op;
      bun_d.rd      = rd;
      bun_d.rs_val  = rs_val;
      bun_d.rt_val  = rt_val;
      bun_d.imm     = sext_imm(inst_i[IMM_LSB +: IMM_W]);
      bun_d.is_load = (op == OP_LOAD);
      bun_d.pc      = pc_i;
    end
  end
  // output register, cleared asynchronously on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bun_q <= '0;
    else     bun_q <= bun_d;
  end
  assign v_o       = bun_q.v;
  assign op_o      = bun_q.op;
  assign rd_o      = bun_q.rd;
  assign rs_val_o  = bun_q.rs_val;
  assign rt_val_o  = bun_q.rt_val;
  assign imm_o     = bun_q.imm;
  assign is_load_o = bun_q.is_load;
  assign pc_o      = bun_q.pc;
endmodule

// File: tb/tb_idecode.sv
// tb_idecode: scoreboard bench for idecode with directed scenarios and randomized traffic
module tb_idecode;
  logic        clk, rst, v_i, stall_i, flush_i, wb_en_i;
  logic [31:0] inst_i, pc_i, wb_data_i;
  logic [4:0]  wb_reg_i;
  logic        stall_o, v_o, is_load_o;
  logic [5:0]  op_o;
  logic [4:0]  rd_o;
  logic [31:0] rs_val_o, rt_val_o, imm_o, pc_o;

  idecode dut (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_i(stall_i), .stall_o(stall_o), .flush_i(flush_i),
    .wb_en_i(wb_en_i), .wb_reg_i(wb_reg_i), .wb_data_i(wb_data_i),
    .v_o(v_o), .op_o(op_o), .rd_o(rd_o), .rs_val_o(rs_val_o), .rt_val_o(rt_val_o),
    .imm_o(imm_o), .is_load_o(is_load_o), .pc_o(pc_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] rs, rt, imm;
    logic        ld;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] regs[32];
  bit          mv, mld, exp_stall, act_stall;
  logic [4:0]  mrd;
  int          total = 0, bad = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] i, input bit wen, input logic [4:0] wr, input logic [31:0] wd);
    if (i == 0) return 32'h0;
`ifdef IDECODE_WB_BYPASS_EN
    if (wen && wr == i) return wd;
`endif
    return regs[i];
  endfunction

  task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc, input bit st, input bit fl,
                      input bit wen, input logic [4:0] wr, input logic [31:0] wd);
    bit   hz;
    exp_t e;
    v_i = v; inst_i = inst; pc_i = pc; stall_i = st; flush_i = fl;
    wb_en_i = wen; wb_reg_i = wr; wb_data_i = wd;
    hz = mv && mld && mrd != 0 && v && (mrd == inst[20:16] || mrd == inst[15:11]);
    exp_stall = v && (st || hz) && !fl;
    e.op  = inst[31:26];
    e.rd  = inst[25:21];
    e.rs  = rd_reg(inst[20:16], wen, wr, wd);
    e.rt  = rd_reg(inst[15:11], wen, wr, wd);
    e.imm = 32'($signed(inst[15:0]));
    e.ld  = inst[31:26] == 6'h23;
    e.pc  = pc;
    #1 act_stall = stall_o;
    @(posedge clk);
    if (fl) mv = 0;
    else if (st) ;
    else if (hz) mv = 0;
    else begin
      mv = v; mrd = e.rd; mld = e.ld;
      if (v) q.push_back(e);
    end
    if (wen && wr != 0) regs[wr] = wd;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) regs[i] = 0;
    mv = 0; mld = 0; mrd = 0; exp_stall = 0;
    q.delete();
  endtask

  task automatic idle_inputs();
    v_i = 0; inst_i = 0; pc_i = 0; stall_i = 0; flush_i = 0;
    wb_en_i = 0; wb_reg_i = 0; wb_data_i = 0;
  endtask

  task automatic chk_reset_outs(input string n);
    chk({n, "_v"}, v_o, 0);
    chk({n, "_stall"}, stall_o, 0);
    chk({n, "_ld"}, is_load_o, 0);
    chk({n, "_fields"}, {op_o, rd_o, rs_val_o, rt_val_o, imm_o, pc_o} == 0, 1);
  endtask

  // monitor: every presented bundle is either consumed (no stall) or killed (flush)
  always @(negedge clk) begin
    if (!rst) begin
      chk("stall_o", stall_o, exp_stall);
      if (v_o && flush_i) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (v_o && !stall_i) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bundle_unexpected got_pc=%0h want=none", pc_o);
        end else begin
          exp_t e;
          exp_t a;
          e = q.pop_front();
          a = '{op_o, rd_o, rs_val_o, rt_val_o, imm_o, is_load_o, pc_o};
          if (a !== e) begin
            bad++;
            $display("FAIL bundle got=%h want=%h", a, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] inst, pc;
  bit          v, held;

  initial begin
    clear_model();
    idle_inputs();
    rst = 1;
    v_i = 1; stall_i = 1;
    #1 chk_reset_outs("por");
    repeat (2) @(posedge clk);
    #1 rst = 0; idle_inputs();

    // reset during operation, mid-stall
    step(0, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF);
    step(1, {6'h23, 5'd5, 5'd3, 16'h8001}, 32'h10, 0, 0, 0, 0, 0);
    chk("pre_rst_rs", rs_val_o, 32'hDEADBEEF);
    step(1, {6'h00, 5'd1, 5'd2, 5'd2, 11'h0}, 32'h14, 1, 0, 0, 0, 0);
    #2 rst = 1;
    clear_model();
    #1 chk_reset_outs("rst_mid");
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("rst_hold");
    rst = 0; idle_inputs();
    step(1, {6'h00, 5'd1, 5'd3, 5'd3, 11'h0}, 32'h20, 0, 0, 0, 0, 0);
    chk("r3_cleared", rs_val_o, 0);

    // basic decode and sign extension
    step(0, 0, 0, 0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 0, 1, 2, 7);
    step(1, {6'h00, 5'd4, 5'd1, 5'd2, 11'h0}, 32'h40, 0, 0, 0, 0, 0);
    chk("basic_v", v_o, 1);
    chk("basic_rd", rd_o, 4);
    chk("basic_rs", rs_val_o, 5);
    chk("basic_rt", rt_val_o, 7);
    chk("basic_pc", pc_o, 32'h40);
    step(1, {6'h00, 5'd0, 5'd0, 16'h8001}, 32'h44, 0, 0, 0, 0, 0);
    chk("sext", imm_o, 32'hFFFF8001);
    step(1, {6'h00, 5'd0, 5'd0, 16'h7FFF}, 32'h48, 0, 0, 0, 0, 0);
    chk("sext_pos", imm_o, 32'h00007FFF);

    // load-use hazard
    step(1, {6'h23, 5'd6, 5'd1, 16'h0004}, 32'h50, 0, 0, 0, 0, 0);
    chk("load_flag", is_load_o, 1);
    step(1, {6'h00, 5'd7, 5'd6, 5'd2, 11'h0}, 32'h54, 0, 0, 0, 0, 0);
    chk("lu_stall", act_stall, 1);
    chk("lu_bubble", v_o, 0);
    step(1, {6'h00, 5'd7, 5'd6, 5'd2, 11'h0}, 32'h54, 0, 0, 0, 0, 0);
    chk("lu_nostall", act_stall, 0);
    chk("lu_issue", v_o, 1);
    chk("lu_pc", pc_o, 32'h54);
    step(1, {6'h23, 5'd0, 5'd1, 16'h0}, 32'h58, 0, 0, 0, 0, 0);
    step(1, {6'h00, 5'd7, 5'd0, 5'd0, 11'h0}, 32'h5C, 0, 0, 0, 0, 0);
    chk("r0_nostall", act_stall, 0);
    chk("r0_issue", v_o, 1);

    // stall hold then flush
    step(1, {6'h00, 5'd8, 5'd1, 5'd2, 11'h0}, 32'h60, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, {6'h00, 5'd9, 5'd2, 5'd1, 11'h0}, 32'h64, 1, 0, 0, 0, 0);
      chk("hold_stall", act_stall, 1);
      chk("hold_out", {v_o, rd_o, rs_val_o, rt_val_o, pc_o[15:0]}, {1'b1, 5'd8, 32'd5, 32'd7, 16'h60});
    end
    step(1, {6'h00, 5'd9, 5'd2, 5'd1, 11'h0}, 32'h64, 1, 1, 0, 0, 0);
    chk("flush_stall", act_stall, 0);
    chk("flush_v", v_o, 0);

    // writeback bypass and r0
    step(0, 0, 0, 0, 0, 1, 9, 32'h1111);
    step(1, {6'h00, 5'd2, 5'd9, 5'd0, 11'h0}, 32'h70, 0, 0, 1, 9, 32'h1234);
`ifdef IDECODE_WB_BYPASS_EN
    chk("bypass", rs_val_o, 32'h1234);
`else
    chk("no_bypass", rs_val_o, 32'h1111);
`endif
    step(1, {6'h00, 5'd2, 5'd9, 5'd0, 11'h0}, 32'h74, 0, 0, 1, 0, 32'hFFFF);
    chk("r9_after", rs_val_o, 32'h1234);
    chk("r0_same", rt_val_o, 0);
    step(1, {6'h00, 5'd2, 5'd0, 5'd0, 11'h0}, 32'h78, 0, 0, 0, 0, 0);
    chk("r0_after", rs_val_o, 0);

    // randomized traffic; fetch holds its instruction while stall_o is up
    held = 0;
    for (int n = 0; n < 600; n++) begin
      if (!held) begin
        v = ($urandom % 4) != 0;
        inst = {($urandom % 4 == 0) ? 6'h23 : 6'($urandom), 5'($urandom % 8), 5'($urandom % 8),
                5'($urandom % 8), 11'($urandom)};
        pc = $urandom;
      end
      step(v, inst, pc, ($urandom % 5) == 0, ($urandom % 10) == 0, ($urandom % 2) == 1,
           5'($urandom % 8), $urandom);
      held = exp_stall;
    end

    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Decode stage directly downstream of the instruction fetch stage.
- Consumes the fetched instruction word, valid bit and PC. Extracts fields, reads two source registers from an internal register file and sign-extends the immediate.
- Presents one registered decode bundle to the execute stage with 1-cycle latency.
- Owns load-use hazard detection, flush on taken branch, and the register-file write port driven by writeback.

Parameters:
- WORD, 32, data/instruction width
- ADDR, 32, PC width
- NREG, 32, number of architectural registers (r0 reads as zero)
- RIDX, 5, register index width (log2 NREG)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- v_i  in  1  fetch bundle valid
- inst_i  in  WORD  fetched instruction
- pc_i  in  ADDR  PC of inst_i
- stall_i  in  1  execute stage cannot accept
- stall_o  out  1  hold request to fetch stage
- flush_i  in  1  taken branch resolved in execute; kill the decode bundle
- wb_en_i  in  1  writeback enable
- wb_reg_i  in  RIDX  writeback register index
- wb_data_i  in  WORD  writeback data
- v_o  out  1  decode bundle valid
- op_o  out  6  opcode
- rd_o  out  RIDX  destination register
- rs_val_o  out  WORD  source 1 value
- rt_val_o  out  WORD  source 2 value
- imm_o  out  WORD  sign-extended imm16
- is_load_o  out  1  opcode == 6'h23
- pc_o  out  ADDR  PC of bundle

Behaviour:
- Instruction format (fixed):
  - op = inst[31:26], rd = inst[25:21], rs = inst[20:16], rt = inst[15:11], imm = inst[15:0]
  - imm_o = {{WORD-16{imm[15]}}, imm}
- Register file: NREG x WORD, asynchronous combinational read of rs and rt; synchronous write on posedge when wb_en_i and wb_reg_i != 0.
  - Writes to r0 are discarded; r0 reads 0.
- Hazard: hz = v_o & is_load_o & (rd_o != 0) & v_i & ((rd_o == rs) | (rd_o == rt)).
- stall_o = v_i & (stall_i | hz) & ~flush_i.
- Register update priority, evaluated each posedge:
  1. flush_i: v_o <= 0; other outputs don't-care. Overrides stall_i and hz.
  2. stall_i: all output registers hold.
  3. hz: v_o <= 0 (bubble inserted); fetch holds the instruction; it re-decodes next cycle.
  4. else: all output registers load from the decoded inputs; v_o <= v_i.
- An invalid input (v_i = 0) still loads the fields; consumers ignore them while v_o = 0.
- Reset: all output registers and every register-file entry are cleared to 0 immediately on rst assertion, including mid-stall.
  - v_o, stall_o and is_load_o are 0 during reset.
  - Operation resumes on the first posedge after deassertion.
- Widths: no arithmetic beyond sign extension; ADDR is independent of WORD.

Optional Feature:
- Macro: IDECODE_WB_BYPASS_EN
- Defined: a read whose index matches wb_reg_i while wb_en_i = 1 (index != 0) returns wb_data_i in the same cycle (write-first).
- Undefined: such a read returns the old register value; software must separate the writer and the reader by one instruction.

Decomposition:
- Shared package/include holds:
  - WORD, ADDR, NREG, RIDX
  - opcode constants (OP_LOAD = 6'h23, OP_STORE = 6'h2B, OP_BEQ = 6'h04)
  - instruction field bit positions
- One sub-module: regfile (2 read, 1 write, r0 zero, owns the bypass macro). Hazard and pipeline-register logic live in idecode.

Test Plan:
- Reset during operation:
  - Write r3 = 0xDEADBEEF, assert rst for 2 cycles.
  - Expect v_o = 0, all outputs 0; reading r3 afterwards returns 0.
- Basic decode:
  - Preload r1 = 5 and r2 = 7 via writeback.
  - Drive v_i = 1, inst = {6'h00, 5'd4, 5'd1, 5'd2, 11'h0}, pc = 0x40.
  - Next cycle expect v_o = 1, rd_o = 4, rs_val_o = 5, rt_val_o = 7, pc_o = 0x40.
  - Check sign extension separately: imm 0x8001 -> imm_o = 0xFFFF8001.
- Load-use hazard:
  - Decode load into r6, then an instruction reading rs = 6.
  - Expect one cycle with stall_o = 1 and v_o = 0 (bubble).
  - Then the dependent instruction issues with v_o = 1.
  - Repeat with rd = 0: expect no stall.
- Stall hold versus flush:
  - Hold stall_i = 1 for 3 cycles: outputs stay constant and stall_o = v_i.
  - Assert flush_i together with stall_i: next cycle v_o = 0, stall_o = 0.
- Writeback bypass:
  - Same cycle: wb r9 = 0x1234 and decode reading rs = 9.
  - With IDECODE_WB_BYPASS_EN: rs_val_o = 0x1234.
  - Without it: rs_val_o = old r9 value.
  - Writeback to r0 leaves r0 reading 0.
